// File: rtl/mul_div_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mul_div_sequencer_pkg
//   Shared types and constants for the RV32M multiply/divide sequencer.
//   - XLEN_DEFAULT       : default operand/result width
//   - ALL_ONES / INT_MIN : special results for divide-by-zero and signed overflow
//   - mul_div_op_e       : func3 encodings of the M-extension ops
//   - mul_div_state_e    : sequencer FSM states
//   - op_* helpers       : decode of operand signedness and op class
// -----------------------------------------------------------------------------
package mul_div_sequencer_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [XLEN_DEFAULT-1:0] ALL_ONES = {XLEN_DEFAULT{1'b1}};
    localparam logic [XLEN_DEFAULT-1:0] INT_MIN  = {1'b1, {(XLEN_DEFAULT-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mul_div_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mul_div_state_e;

    // Divide class (DIV/DIVU/REM/REMU) is func3[2] set.
    function automatic logic op_is_div(input mul_div_op_e op);
        return op[2];
    endfunction

    // Remainder ops (REM/REMU) are func3 = 11x.
    function automatic logic op_is_rem(input mul_div_op_e op);
        return op[2] & op[1];
    endfunction

    // MUL is treated as signed x signed; its low half is identical either way.
    function automatic logic op_signed_a(input mul_div_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_signed_b(input mul_div_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mul_div_iter_core.sv
// -----------------------------------------------------------------------------
// mul_div_iter_core
//   Unsigned one-bit-per-step datapath shared by multiply and divide.
//   Multiply: shift-add on the multiplier LSB into a 2*XLEN accumulator.
//   Divide  : restoring division, one quotient bit per step, MSB first.
//   Ports:
//     clk, rst_n  : clock, async active-low reset
//     load        : capture magnitudes, clear accumulator/remainder/counter
//     step        : perform one iteration and advance the counter
//     is_div      : captured at load; selects divide vs multiply datapath
//     mag_a/mag_b : multiplier/dividend and multiplicand/divisor magnitudes
//     last        : counter is on the final iteration (XLEN-1)
//     product     : full 2*XLEN unsigned product
//     quotient    : unsigned quotient
//     remainder   : unsigned remainder
// -----------------------------------------------------------------------------
module mul_div_iter_core
    import mul_div_sequencer_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   mag_a,
    input  logic [XLEN-1:0]   mag_b,
    output logic              last,
    output logic [2*XLEN-1:0] product,
    output logic [XLEN-1:0]   quotient,
    output logic [XLEN-1:0]   remainder
);

    localparam int               CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    // acc: {product high, multiplier/product low} for multiply;
    //      low half holds the dividend shifting out / quotient shifting in.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_div_q, is_div_d;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              q_bit;

    always_comb begin
        acc_d     = acc_q;
        rem_d     = rem_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        mul_sum   = '0;
        div_shift = '0;
        div_diff  = '0;
        q_bit     = 1'b0;

        if (load) begin
            acc_d    = {{XLEN{1'b0}}, mag_a};
            rem_d    = '0;
            opnd_d   = mag_b;
            cnt_d    = '0;
            is_div_d = is_div;
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
            if (is_div_q) begin
                // Working remainder is XLEN+1 bits: the shifted partial
                // remainder can exceed XLEN bits before the trial subtract.
                div_shift = {rem_q, acc_q[XLEN-1]};
                div_diff  = div_shift - {1'b0, opnd_q};
                q_bit     = (div_shift >= {1'b0, opnd_q});
                rem_d     = q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                acc_d     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], q_bit};
            end else begin
                // Add into the high half (keeping the carry), then shift the
                // whole accumulator right so the next multiplier bit is at LSB.
                mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                          (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
                acc_d   = {mul_sum, acc_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            rem_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
        end
    end

    assign last      = (cnt_q == CNT_LAST);
    assign product   = acc_q;
    assign quotient  = acc_q[XLEN-1:0];
    assign remainder = rem_q;

endmodule

// File: rtl/mul_div_sequencer.sv
// -----------------------------------------------------------------------------
// mul_div_sequencer
//   Multi-cycle RV32M multiply/divide sequencer for the Execute stage.
//   Latches an op, converts operands to magnitudes, iterates XLEN steps in
//   mul_div_iter_core, restores the sign and presents a one-cycle result.
//   Divide-by-zero and signed overflow skip the iteration entirely.
//   Ports:
//     clk, rst_n  : clock, async active-low reset
//     flush       : synchronous abort; beats everything including accept
//     opValid     : EX presents an M-extension op
//     opReady     : sequencer idle and able to accept
//     func3       : op select (see mul_div_op_e)
//     operandA/B  : rs1 / rs2 values
//     stall       : hold IF/ID/EX while an op is pending or in flight
//     resValid    : one-cycle result strobe (in DONE)
//     result      : result, held until the next completion
//     dbg_state   : current FSM state
//
//   Handshake: an op is accepted on a rising edge where opValid && opReady
//   && !flush. opReady is high only in IDLE. EX keeps opValid and operands
//   stable under stall; the sequencer ignores them after acceptance.
// -----------------------------------------------------------------------------
module mul_div_sequencer
    import mul_div_sequencer_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             opValid,
    output logic             opReady,
    input  logic [2:0]       func3,
    input  logic [XLEN-1:0]  operandA,
    input  logic [XLEN-1:0]  operandB,
    output logic             stall,
    output logic             resValid,
    output logic [XLEN-1:0]  result,
    output mul_div_state_e   dbg_state
);

    localparam logic [XLEN-1:0] RES_ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] RES_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    mul_div_state_e  state_q, state_d;
    mul_div_op_e     op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            neg_q, neg_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;
    logic            res_valid_q, res_valid_d;
    logic [XLEN-1:0] result_q, result_d;

    // Operand pre-processing (used in PREP)
    logic            neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            is_div0, is_ovf;

    // Core interface
    logic              core_load, core_step, core_last;
    logic [2*XLEN-1:0] core_product;
    logic [XLEN-1:0]   core_quotient, core_remainder;

    // Sign post-processing (used in FIX)
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_value;

    always_comb begin
        neg_a   = op_signed_a(op_q) & a_q[XLEN-1];
        neg_b   = op_signed_b(op_q) & b_q[XLEN-1];
        mag_a   = neg_a ? (~a_q + 1'b1) : a_q;
        mag_b   = neg_b ? (~b_q + 1'b1) : b_q;
        is_div0 = op_is_div(op_q) && (b_q == '0);
        is_ovf  = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                  (a_q == RES_INT_MIN) && (b_q == RES_ALL_ONES);
    end

    always_comb begin
        prod_fix = neg_q ? (~core_product + 1'b1)   : core_product;
        quo_fix  = neg_q ? (~core_quotient + 1'b1)  : core_quotient;
        rem_fix  = neg_q ? (~core_remainder + 1'b1) : core_remainder;

        if (div0_q) begin
            fix_value = op_is_rem(op_q) ? a_q : RES_ALL_ONES;
        end else if (ovf_q) begin
            fix_value = op_is_rem(op_q) ? '0 : RES_INT_MIN;
        end else begin
            case (op_q)
                OP_MUL:                       fix_value = prod_fix[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: fix_value = prod_fix[2*XLEN-1:XLEN];
                OP_DIV, OP_DIVU:              fix_value = quo_fix;
                default:                      fix_value = rem_fix;
            endcase
        end
    end

    assign core_load = (state_q == ST_PREP);
    assign core_step = (state_q == ST_CALC);

    mul_div_iter_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (core_load),
        .step      (core_step),
        .is_div    (op_is_div(op_q)),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .last      (core_last),
        .product   (core_product),
        .quotient  (core_quotient),
        .remainder (core_remainder)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        neg_d       = neg_q;
        div0_d      = div0_q;
        ovf_d       = ovf_q;
        res_valid_d = 1'b0;
        result_d    = result_q;

        if (flush) begin
            // Abort wins over accept and completion; result keeps last value.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (opValid) begin
                        op_d    = mul_div_op_e'(func3);
                        a_d     = operandA;
                        b_d     = operandB;
                        state_d = ST_PREP;
                    end
                end
                ST_PREP: begin
                    // Remainder takes the dividend's sign; everything else
                    // takes the XOR of operand signs.
                    neg_d   = op_is_rem(op_q) ? neg_a : (neg_a ^ neg_b);
                    div0_d  = is_div0;
                    ovf_d   = is_ovf;
                    state_d = (is_div0 || is_ovf) ? ST_FIX : ST_CALC;
                end
                ST_CALC: begin
                    if (core_last) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    result_d    = fix_value;
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MUL;
            a_q         <= '0;
            b_q         <= '0;
            neg_q       <= 1'b0;
            div0_q      <= 1'b0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            neg_q       <= neg_d;
            div0_q      <= div0_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
            result_q    <= result_d;
        end
    end

    assign opReady   = (state_q == ST_IDLE);
    // Low in DONE so the pipeline advances and captures result that cycle.
    assign stall     = ((state_q == ST_IDLE) && opValid) ||
                       (state_q == ST_PREP) || (state_q == ST_CALC) ||
                       (state_q == ST_FIX);
    assign resValid  = res_valid_q;
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_div_sequencer
//   Scoreboard bench: the driver pushes the expected result and completion
//   edge when an op is accepted; a monitor pops and compares whenever
//   resValid is seen. Expected values come from directed constants or from
//   a plain-arithmetic RV32M reference model.
// -----------------------------------------------------------------------------
module tb_mul_div_sequencer;
    import mul_div_sequencer_pkg::*;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            opValid;
    logic            opReady;
    logic [2:0]      func3;
    logic [XLEN-1:0] operandA;
    logic [XLEN-1:0] operandB;
    logic            stall;
    logic            resValid;
    logic [XLEN-1:0] result;
    mul_div_state_e  dbg_state;

    int checks;
    int passes;
    int edge_cnt;
    int pulse_cnt;

    logic [XLEN-1:0] exp_q[$];
    int              edge_q[$];

    mul_div_sequencer #(
        .XLEN (XLEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .opValid   (opValid),
        .opReady   (opReady),
        .func3     (func3),
        .operandA  (operandA),
        .operandB  (operandB),
        .stall     (stall),
        .resValid  (resValid),
        .result    (result),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] ref_result(input logic [2:0] f,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        sp = 0;
        up = 0;
        case (f)
            3'b000: begin sp = sa * sb; return sp[31:0]; end
            3'b001: begin sp = sa * sb; return sp[63:32]; end
            3'b010: begin sp = sa * longint'(ub); return sp[63:32]; end
            3'b011: begin up = ua * ub; return up[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sp = sa / sb;
                return sp[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                up = ua / ub;
                return up[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                sp = sa % sb;
                return sp[31:0];
            end
            default: begin
                if (b == 0) return a;
                up = ua % ub;
                return up[31:0];
            end
        endcase
    endfunction

    // Edges from accept to the edge that enters DONE.
    function automatic int ref_latency(input logic [2:0] f,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
        if (f[2] && b == 0) return 2;
        if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 2;
        return XLEN + 2;
    endfunction

    function automatic logic [XLEN-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        #1;
        if (rst_n && resValid) begin
            logic [XLEN-1:0] e;
            int              n;
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resvalid: got result %h with no op outstanding (t=%0t)",
                         result, $time);
            end else begin
                e = exp_q.pop_front();
                n = edge_q.pop_front();
                check("result", result, e);
                check("latency_edge", 32'(edge_cnt), 32'(n));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue_op(input logic [2:0] f, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
        int lat;
        int stall_cnt;
        bit seen;
        lat = ref_latency(f, a, b);
        @(negedge clk);
        func3    = f;
        operandA = a;
        operandB = b;
        opValid  = 1'b1;
        #1;
        check("stall_on_valid", 32'(stall), 32'd1);
        check("ready_idle", 32'(opReady), 32'd1);
        @(posedge clk);
        #1;
        exp_q.push_back(exp);
        edge_q.push_back(edge_cnt + lat);
        // Operands change after accept; the latched op must be unaffected.
        opValid  = 1'b0;
        func3    = 3'($urandom);
        operandA = $urandom;
        operandB = $urandom;
        stall_cnt = 0;
        seen      = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (resValid) begin
                seen = 1;
            end else begin
                if (stall) stall_cnt++;
                @(posedge clk);
                #1;
            end
        end
        check("completion_timeout", 32'(seen), 32'd1);
        check("stall_cycles", 32'(stall_cnt), 32'(lat));
        check("stall_low_done", 32'(stall), 32'd0);
        check("ready_low_done", 32'(opReady), 32'd0);
        @(posedge clk);
        #1;
        check("resvalid_one_cycle", 32'(resValid), 32'd0);
    endtask

    // ---------------- directed table ----------------
    logic [2:0]      t_f[14];
    logic [XLEN-1:0] t_a[14];
    logic [XLEN-1:0] t_b[14];
    logic [XLEN-1:0] t_e[14];

    initial begin
        t_f[0]  = 3'b000; t_a[0]  = 32'd7;          t_b[0]  = 32'hFFFF_FFFD; t_e[0]  = 32'hFFFF_FFEB;
        t_f[1]  = 3'b001; t_a[1]  = 32'h8000_0000;  t_b[1]  = 32'h8000_0000; t_e[1]  = 32'h4000_0000;
        t_f[2]  = 3'b011; t_a[2]  = 32'hFFFF_FFFF;  t_b[2]  = 32'hFFFF_FFFF; t_e[2]  = 32'hFFFF_FFFE;
        t_f[3]  = 3'b010; t_a[3]  = 32'hFFFF_FFFF;  t_b[3]  = 32'd2;         t_e[3]  = 32'hFFFF_FFFF;
        t_f[4]  = 3'b101; t_a[4]  = 32'd100;        t_b[4]  = 32'd7;         t_e[4]  = 32'd14;
        t_f[5]  = 3'b111; t_a[5]  = 32'd100;        t_b[5]  = 32'd7;         t_e[5]  = 32'd2;
        t_f[6]  = 3'b100; t_a[6]  = 32'hFFFF_FFF9;  t_b[6]  = 32'd2;         t_e[6]  = 32'hFFFF_FFFD;
        t_f[7]  = 3'b110; t_a[7]  = 32'hFFFF_FFF9;  t_b[7]  = 32'd2;         t_e[7]  = 32'hFFFF_FFFF;
        t_f[8]  = 3'b100; t_a[8]  = 32'd5;          t_b[8]  = 32'd0;         t_e[8]  = 32'hFFFF_FFFF;
        t_f[9]  = 3'b110; t_a[9]  = 32'd5;          t_b[9]  = 32'd0;         t_e[9]  = 32'd5;
        t_f[10] = 3'b100; t_a[10] = 32'h8000_0000;  t_b[10] = 32'hFFFF_FFFF; t_e[10] = 32'h8000_0000;
        t_f[11] = 3'b110; t_a[11] = 32'h8000_0000;  t_b[11] = 32'hFFFF_FFFF; t_e[11] = 32'h0;
        t_f[12] = 3'b111; t_a[12] = 32'd5;          t_b[12] = 32'd0;         t_e[12] = 32'd5;
        t_f[13] = 3'b101; t_a[13] = 32'd5;          t_b[13] = 32'd0;         t_e[13] = 32'hFFFF_FFFF;
    end

    // ---------------- main sequence ----------------
    initial begin
        int pulses_before;
        checks    = 0;
        passes    = 0;
        pulse_cnt = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        opValid   = 1'b0;
        func3     = 3'b000;
        operandA  = '0;
        operandB  = '0;

        // Reset state
        #12;
        check("rst_resvalid", 32'(resValid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_ready", 32'(opReady), 32'd1);
        check("rst_stall_idle", 32'(stall), 32'd0);
        opValid = 1'b1;
        #1;
        check("rst_stall_follows_valid", 32'(stall), 32'd1);
        opValid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed ops
        for (int i = 0; i < 14; i++) begin
            issue_op(t_f[i], t_a[i], t_b[i], t_e[i]);
        end

        // Flush at CALC iteration 10: no result, result register held
        @(negedge clk);
        func3 = 3'b000; operandA = 32'd1234; operandB = 32'd5678; opValid = 1'b1;
        @(posedge clk);
        #1;
        opValid = 1'b0;
        pulses_before = pulse_cnt;
        repeat (11) @(posedge clk);
        @(negedge clk);
        check("calc_before_flush", 32'(dbg_state), 32'(ST_CALC));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_to_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("flush_ready", 32'(opReady), 32'd1);
        check("flush_result_held", result, 32'hFFFF_FFFF);
        repeat (40) @(posedge clk);
        #1;
        check("flush_no_pulse", 32'(pulse_cnt), 32'(pulses_before));
        issue_op(3'b101, 32'd9, 32'd3, 32'd3);

        // Reset mid-CALC
        @(negedge clk);
        func3 = 3'b100; operandA = 32'd1000; operandB = 32'd7; opValid = 1'b1;
        @(posedge clk);
        #1;
        opValid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("calc_before_reset", 32'(dbg_state), 32'(ST_CALC));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_resvalid", 32'(resValid), 32'd0);
        check("async_rst_result", result, 32'd0);
        check("async_rst_ready", 32'(opReady), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // opValid together with flush in IDLE: not accepted
        pulses_before = pulse_cnt;
        @(negedge clk);
        func3 = 3'b101; operandA = 32'd8; operandB = 32'd2; opValid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush_blocks_accept", 32'(dbg_state), 32'(ST_IDLE));
        check("flush_blocks_ready", 32'(opReady), 32'd1);
        opValid = 1'b0;
        flush   = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("flush_accept_no_pulse", 32'(pulse_cnt), 32'(pulses_before));

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [2:0]      f;
            logic [XLEN-1:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = rand_operand();
            b = rand_operand();
            issue_op(f, a, b, ref_result(f, a, b));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
